rgb_led_pwm_ctrl: RTL
=====================

RGB_LED_PWM_CTRL -- requirements
Module: rgb_led_pwm_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 390, meaning clk cycles per PWM step (legal range 1..65535); the default gives a ~1 kHz frame at 100 MHz.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz board clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_valid  input  1  config write request.
REQ-005 SHALL have port cfg_ready  output  1  config write can be accepted.
REQ-006 SHALL have port cfg_addr  input  4  register address.
REQ-007 SHALL have port cfg_wdata  input  8  write data.
REQ-008 SHALL have port cfg_err  output  1  one-cycle pulse when a write hits an unmapped address.
REQ-009 SHALL have port led_r  output  4  red channel of RGB LEDs 0..3.
REQ-010 SHALL have port led_g  output  4  green channel of RGB LEDs 0..3.
REQ-011 SHALL have port led_b  output  4  blue channel of RGB LEDs 0..3.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each PWM frame boundary.

Function
REQ-013 A write SHALL be accepted in any cycle where cfg_valid && cfg_ready.
REQ-014 Address map: addr 3*i+0/1/2 = shadow duty R/G/B of LED i (i=0..3, addr 0..11); addr 12 = COMMIT (data ignored); addr 13 = ENABLE (bit0; bits 7:1 ignored); addr 14..15 unmapped.
REQ-015 A write to an unmapped address SHALL be accepted, change no state, and pulse cfg_err high the following cycle.
REQ-016 Prescaler: counts 0..PRESCALE_DIV-1, then wraps to 0; step = prescaler at PRESCALE_DIV-1.
REQ-017 pwm_cnt: 8-bit, increments on step, wraps 255->0; wrap = step && pwm_cnt==255.
REQ-018 An accepted COMMIT SHALL set commit_pending; at the next wrap, all 12 active duties SHALL load from shadow and commit_pending SHALL clear.
REQ-019 cfg_ready SHALL equal !commit_pending (combinational); shadow writes cannot occur while a commit is pending.
REQ-020 A COMMIT accepted in the same cycle as a wrap SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-021 Shadow writes without COMMIT SHALL NOT affect outputs.
REQ-022 An ENABLE write SHALL take effect on the outputs 2 cycles after acceptance, with no frame alignment.
REQ-023 Each channel output SHALL be registered: next = enable && (active_duty > pwm_cnt); duty 0 = always off, duty 255 = on 255 of 256 steps.
REQ-024 Output latency: the output SHALL reflect pwm_cnt one cycle after the counter value.
REQ-025 frame_tick SHALL be registered and high for exactly one cycle, the cycle after each wrap.
REQ-026 Outputs SHALL be glitch-free; each channel SHALL change at most twice per frame.

Reset
REQ-027 On rst high at a clk edge: prescaler, pwm_cnt, all shadow and active duties, enable, and commit_pending SHALL be 0.
REQ-028 While and after reset: led_r/g/b=0, frame_tick=0, cfg_err=0, cfg_ready=1.
REQ-029 Reset mid-frame or with a commit pending SHALL discard the pending commit and all duties; the first frame restarts with pwm_cnt=0.
REQ-030 cfg_valid during rst SHALL be ignored.

Verification (PRESCALE_DIV=1, frame = 256 cycles)
REQ-031 Write addr0=0x40, addr13=1, COMMIT -> cfg_ready low until the next wrap; then led_r[0] high for exactly 64 cycles per frame, all other outputs 0.
REQ-032 Duties 0x00 and 0xFF on led_g[1]/led_b[1] -> never high / high 255 of 256 cycles respectively; frame_tick period = 256 cycles.
REQ-033 COMMIT issued in the wrap cycle -> old duties persist one more full frame; new duties appear after the next wrap.
REQ-034 Write addr 14 -> cfg_err=1 for one cycle, no output or register change.
REQ-035 Write ENABLE=0 mid-frame -> all outputs 0 two cycles later; ENABLE=1 resumes with the unchanged active duties.
REQ-036 Assert rst with a commit pending -> outputs 0 and cfg_ready=1 next cycle; after release, pwm_cnt restarts at 0 and no duties are applied.

Source files
------------

// File: rtl/rgb_led_pwm_ctrl.sv
// Four RGB LED PWM controller with shadowed duty registers, frame-aligned commit
// and a config write port with unmapped-address error pulse.
module rgb_led_pwm_ctrl #(
   parameter int unsigned PRESCALE_DIV = 390
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [3:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   output logic       cfg_err,
   output logic [3:0] led_r,
   output logic [3:0] led_g,
   output logic [3:0] led_b,
   output logic       frame_tick
);

   localparam int unsigned PrescW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE_DIV - 1);
   localparam int unsigned NumChan = 12;

   localparam logic [3:0] AddrCommit = 4'd12;
   localparam logic [3:0] AddrEnable = 4'd13;

   logic [PrescW-1:0] presc_q, presc_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        shadow_q [NumChan];
   logic [7:0]        shadow_d [NumChan];
   logic [7:0]        active_q [NumChan];
   logic [7:0]        active_d [NumChan];
   logic              en_q, en_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic              tick_q, tick_d;
   logic [3:0]        led_r_q, led_r_d;
   logic [3:0]        led_g_q, led_g_d;
   logic [3:0]        led_b_q, led_b_d;

   logic step, wrap, accept;

   assign cfg_ready  = !pend_q;
   assign accept     = cfg_valid && cfg_ready;
   assign step       = (presc_q == PrescMax);
   assign wrap       = step && (cnt_q == 8'hFF);

   always_comb begin
      presc_d  = step ? '0 : presc_q + PrescW'(1);
      cnt_d    = step ? cnt_q + 8'd1 : cnt_q;
      shadow_d = shadow_q;
      en_d     = en_q;
      pend_d   = pend_q;
      err_d    = accept && (cfg_addr > AddrEnable);
      tick_d   = wrap;

      // Only a commit pending before this cycle loads at this wrap; a commit
      // accepted now re-arms pend_d and waits for the following wrap.
      active_d = (wrap && pend_q) ? shadow_q : active_q;
      if (wrap) pend_d = 1'b0;

      if (accept) begin
         for (int unsigned i = 0; i < NumChan; i++) begin
            if (cfg_addr == 4'(i)) shadow_d[i] = cfg_wdata;
         end
         if (cfg_addr == AddrCommit) pend_d = 1'b1;
         if (cfg_addr == AddrEnable) en_d = cfg_wdata[0];
      end

      for (int unsigned i = 0; i < 4; i++) begin
         led_r_d[i] = en_q && (active_q[3*i]   > cnt_q);
         led_g_d[i] = en_q && (active_q[3*i+1] > cnt_q);
         led_b_d[i] = en_q && (active_q[3*i+2] > cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
         en_q     <= 1'b0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         tick_q   <= 1'b0;
         led_r_q  <= '0;
         led_g_q  <= '0;
         led_b_q  <= '0;
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         en_q     <= en_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         tick_q   <= tick_d;
         led_r_q  <= led_r_d;
         led_g_q  <= led_g_d;
         led_b_q  <= led_b_d;
      end
   end

   assign cfg_err    = err_q;
   assign frame_tick = tick_q;
   assign led_r      = led_r_q;
   assign led_g      = led_g_q;
   assign led_b      = led_b_q;

endmodule
